// File: rtl/vga_timing_gen.sv
// 640x480@60 VGA raster generator: pixel divider, sx/sy counters, sync decode,
// frame-stable number shadow and RGB blanking. Define VGA_RGB_PIPE_EN to register the pins.
module vga_timing_gen #(
  parameter int CLK_DIV  = 4,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [47:0] numbers_in,
  input  logic [7:0]  rgb_in,
  output logic [9:0]  sx,
  output logic [9:0]  sy,
  output logic        de,
  output logic        hsync,
  output logic        vsync,
  output logic        frame_start,
  output logic [47:0] numbers_concat,
  output logic [2:0]  vga_r,
  output logic [2:0]  vga_g,
  output logic [1:0]  vga_b
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);

  localparam logic [9:0] H_ACT_L  = 10'(H_ACTIVE);
  localparam logic [9:0] H_SS_L   = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] H_SE_L   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] H_LAST_L = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_ACT_L  = 10'(V_ACTIVE);
  localparam logic [9:0] V_SS_L   = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] V_SE_L   = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [9:0] V_LAST_L = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

  logic [DW-1:0] div_cnt_q, div_cnt_d;
  logic [9:0]    sx_q, sx_d;
  logic [9:0]    sy_q, sy_d;
  logic          frame_start_q, frame_start_d;
  logic [47:0]   numbers_q, numbers_d;
  logic          pix_tick;
  logic          line_end;
  logic          de_c, hsync_c, vsync_c;
  logic [7:0]    rgb_c;

  always_comb begin
    pix_tick      = (div_cnt_q == DIV_MAX);
    div_cnt_d     = pix_tick ? '0 : div_cnt_q + 1'b1;
    line_end      = (sx_q == H_LAST_L);
    sx_d          = sx_q;
    sy_d          = sy_q;
    if (pix_tick) begin
      if (line_end) begin
        sx_d = '0;
        sy_d = (sy_q == V_LAST_L) ? '0 : sy_q + 10'd1;
      end else begin
        sx_d = sx_q + 10'd1;
      end
    end
    // The frame wrap edge both pulses frame_start and loads the number shadow.
    frame_start_d = pix_tick && line_end && (sy_q == V_LAST_L);
    numbers_d     = frame_start_d ? numbers_in : numbers_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_q     <= '0;
      sx_q          <= '0;
      sy_q          <= '0;
      frame_start_q <= 1'b0;
      numbers_q     <= '0;
    end else begin
      div_cnt_q     <= div_cnt_d;
      sx_q          <= sx_d;
      sy_q          <= sy_d;
      frame_start_q <= frame_start_d;
      numbers_q     <= numbers_d;
    end
  end

  always_comb begin
    de_c    = (sx_q < H_ACT_L) && (sy_q < V_ACT_L);
    hsync_c = !((sx_q >= H_SS_L) && (sx_q < H_SE_L));
    vsync_c = !((sy_q >= V_SS_L) && (sy_q < V_SE_L));
    rgb_c   = de_c ? rgb_in : 8'h00;
  end

  assign sx             = sx_q;
  assign sy             = sy_q;
  assign de             = de_c;
  assign frame_start    = frame_start_q;
  assign numbers_concat = numbers_q;

`ifdef VGA_RGB_PIPE_EN
  logic [7:0] rgb_q, rgb_d;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;

  // Syncs share the colour stage so the pins stay one pixel behind sx/sy together.
  always_comb begin
    rgb_d   = pix_tick ? rgb_c   : rgb_q;
    hsync_d = pix_tick ? hsync_c : hsync_q;
    vsync_d = pix_tick ? vsync_c : vsync_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rgb_q   <= 8'h00;
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
    end else begin
      rgb_q   <= rgb_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
    end
  end

  assign hsync                 = hsync_q;
  assign vsync                 = vsync_q;
  assign {vga_r, vga_g, vga_b} = rgb_q;
`else
  assign hsync                 = hsync_c;
  assign vsync                 = vsync_c;
  assign {vga_r, vga_g, vga_b} = rgb_c;
`endif

endmodule
